// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, constants and output-register state type for the
//            instruction fetch stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;
    localparam int INSTR_W          = 32;
    localparam int OFFSET_W         = 16;
    localparam int DEFAULT_RESET_PC = 0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // EMPTY: no instruction held for decode; FULL: out_instr/out_pc valid.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;
endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// ============================================================================
// Module   : fetch_if
// Purpose  : Fetch-stage bus: instruction memory port, fetch/decode handshake
//            and branch redirect inputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   instruction_addr;
    logic [INSTR_W-1:0]  instruction;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [ADDR_W-1:0]   out_pc;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [OFFSET_W-1:0] redirect_offset;

    modport master (
        output instruction_addr, out_valid, out_instr, out_pc,
        input  instruction, out_ready, redirect_valid, redirect_pc, redirect_offset
    );

    modport slave (
        input  instruction_addr, out_valid, out_instr, out_pc,
        output instruction, out_ready, redirect_valid, redirect_pc, redirect_offset
    );
endinterface

`default_nettype wire

// File: rtl/pc_next_logic.sv
// ============================================================================
// Module   : pc_next_logic
// Purpose  : Combinational next-PC select: branch target, pc+1 or hold.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  wire logic [ADDR_W-1:0]   pc,
    input  wire logic                adv,
    input  wire logic                redirect_valid,
    input  wire logic [ADDR_W-1:0]   redirect_pc,
    input  wire logic [OFFSET_W-1:0] redirect_offset,
    output logic      [ADDR_W-1:0]   pc_next
);
    logic [ADDR_W-1:0] w_target;

    // Sign-extending cast keeps the sum modulo 2^ADDR_W, so negative offsets wrap.
    assign w_target = redirect_pc + ADDR_W'(1) + ADDR_W'($signed(redirect_offset));

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = w_target;
        end else if (adv) begin
            pc_next = pc + ADDR_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC register, registered fetch/decode
//            output with valid/ready, branch redirect with one-bubble flush.
//            Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic   clk,
    input  wire logic   rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    fetch_if.master     bus
);
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

    out_state_t          r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_out_instr;
    logic [ADDR_W-1:0]   r_out_pc;
    logic                w_out_valid;
    logic                w_adv;
    logic [ADDR_W-1:0]   w_pc_next;

    assign w_out_valid = (r_state == ST_FULL);
    assign w_adv       = !w_out_valid || bus.out_ready;

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_logic (
        .pc              (r_pc),
        .adv             (w_adv),
        .redirect_valid  (bus.redirect_valid),
        .redirect_pc     (bus.redirect_pc),
        .redirect_offset (bus.redirect_offset),
        .pc_next         (w_pc_next)
    );

    // Redirect flushes the output register even when the decoder is accepting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_pc        <= c_reset_pc;
            r_out_instr <= NOP_INSTR;
            r_out_pc    <= '0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                ST_EMPTY: begin
                    if (!bus.redirect_valid) begin
                        r_state     <= ST_FULL;
                        r_out_instr <= bus.instruction;
                        r_out_pc    <= r_pc;
                    end
                end
                ST_FULL: begin
                    if (bus.redirect_valid) begin
                        r_state <= ST_EMPTY;
                    end else if (bus.out_ready) begin
                        r_out_instr <= bus.instruction;
                        r_out_pc    <= r_pc;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_out_valid && bus.out_ready) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_out_valid && !bus.out_ready && !bus.redirect_valid) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

    assign bus.instruction_addr = r_pc;
    assign bus.out_valid        = w_out_valid;
    assign bus.out_instr        = r_out_instr;
    assign bus.out_pc           = r_out_pc;
endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle/pipelined MIPS core. Owns the program counter, drives the word address into the 16-entry instruction memory, captures the returned 32-bit instruction into a registered fetch/decode output with a valid/ready handshake, and applies branch redirects from the decode/execute side. It sits directly upstream of the instruction memory's address input and directly upstream of the decoder.

## Interface
- ADDR_W, 4: width of the instruction word address; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- instruction_addr  output  ADDR_W  current PC, driven combinationally from the PC register to instruction memory.
- instruction  input  32  instruction read combinationally from memory at instruction_addr.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decoder accepts the output this cycle.
- out_instr  output  32  registered fetched instruction.
- out_pc  output  ADDR_W  PC of out_instr.
- redirect_valid  input  1  taken branch, one-cycle pulse.
- redirect_pc  input  ADDR_W  PC of the branch instruction.
- redirect_offset  input  16  signed word offset (MIPS beq immediate).
- fetch_count  output  32  instructions accepted by decoder (only with FETCH_PERF_CNT_EN).
- stall_count  output  32  cycles with out_valid=1, out_ready=0 (only with FETCH_PERF_CNT_EN).

## Operation
- Reset (rst=0, any time, asynchronous): pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, counters=0. Takes effect immediately, mid-fetch included; first fetch after release at pc=RESET_PC.
- Advance condition: adv = !out_valid || out_ready.
- Priority per cycle: redirect > stall > advance.
- Redirect (redirect_valid=1): pc <= redirect_pc + 1 + sext(redirect_offset), truncated to ADDR_W bits; out_valid <= 0 (flush held/in-flight instruction regardless of out_ready); out_instr/out_pc unchanged.
- Stall (!adv, no redirect): pc, out_valid, out_instr, out_pc hold.
- Advance (adv, no redirect): out_instr <= instruction, out_pc <= pc, out_valid <= 1, pc <= pc + 1 (mod 2^ADDR_W).
- Arithmetic: offset sign-extended to 32 bits, sum taken modulo 2^ADDR_W; negative offsets wrap (pc 1, offset -3 -> 15).
- Wrap: pc 2^ADDR_W-1 advances to 0; no error flag.
- Transfer occurs when out_valid && out_ready at a rising edge; redirect in the same cycle still counts that transfer.
- Two-state view of output register: EMPTY (out_valid=0) -> FULL on advance; FULL -> FULL on advance with ready; FULL -> FULL hold on stall; any -> EMPTY on redirect.

## Timing
- instruction_addr = pc, zero-cycle path; instruction must settle within the same cycle.
- Fetch latency: instruction at pc appears on out_instr one edge after pc is presented.
- After reset release: out_valid=1 after first edge with out_pc=RESET_PC.
- Redirect penalty: redirect in cycle N -> cycle N+1 out_valid=0, instruction_addr=target -> cycle N+2 out_valid=1, out_pc=target. Exactly one bubble.
- Sustained throughput with out_ready=1: one instruction per cycle.
- out_valid never drops without a redirect or reset; out_instr/out_pc stable while out_valid && !out_ready.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_count increments on every transfer, stall_count on every cycle with out_valid && !out_ready && !redirect_valid; both 32-bit, wrap, cleared by reset.
- Undefined: fetch_count and stall_count ports and registers absent; all other behaviour identical.

## Structure
- Shared package fetch_pkg: INSTR_W=32, OFFSET_W=16, default RESET_PC, NOP_INSTR=32'h0000_0000.
- One sub-module pc_next_logic: combinational next-PC select (redirect target, pc+1, hold) from pc, adv, redirect inputs; fetch_unit keeps all registers.

## Test plan
- Reset: assert rst=0 mid-run -> pc=0, out_valid=0, out_instr=0 immediately; release -> out_pc=0, out_instr=mem[0] after one edge.
- Streaming, out_ready=1: out_pc 0,1,2,3,4,5 on consecutive cycles, out_instr matching mem[0..5] (e.g. mem[0]=32'h8C01_0000).
- Stall: out_ready=0 for 3 cycles at out_pc=2 -> out_pc/out_instr held, instruction_addr stays 3, stall_count +3 (with macro); resume -> out_pc 3.
- Branch: redirect_pc=2, offset=1 -> one bubble, next valid out_pc=4; offset=16'hFFFD from pc=1 -> out_pc=15.
- Wrap: streaming through pc=15 -> next out_pc=0, no gap.
- Redirect during stall: out_valid=1, out_ready=0, redirect to 8 -> out_valid=0 next cycle, no transfer counted, out_pc=8 one cycle later.
